// File: rtl/sa_cache_ram_top_if.sv
// CPU load/store port of the set-associative cache.
// Signals:
//   cpu_addr  - request byte address (word aligned, addr[1:0] ignored)
//   cpu_wdata - write data
//   cpu_rw    - 1 = write, 0 = read
//   cpu_valid - request present
//   cpu_rdata - registered read data, held until the next read completes
//   cpu_ready - registered one-cycle completion pulse
// Modports: master (CPU side), slave (cache side).
interface sa_cache_ram_top_if #(
    parameter int unsigned ADDR_W = 20
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_rw;
    logic              cpu_valid;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rw, cpu_valid,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rw, cpu_valid,
        output cpu_rdata, cpu_ready
    );
endinterface

// File: rtl/sa_cache_ram_top.sv
// Two-way set-associative, write-back, write-allocate data cache with an
// internal single-port byte-enabled backing RAM.
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset (invalidates all lines, abandons request)
//   cpu - sa_cache_ram_top_if.slave: valid/ready load/store port
module sa_cache_ram_top #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned NUM_SETS  = 256,
    parameter int unsigned RAM_WORDS = 2 ** (ADDR_W - 2)
) (
    input logic               clk,
    input logic               rst,
    sa_cache_ram_top_if.slave cpu
);
    localparam int unsigned IdxW  = $clog2(NUM_SETS);
    localparam int unsigned WordW = ADDR_W - 2;
    localparam int unsigned TagW  = WordW - IdxW;

    typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StAllocate, StRefill} state_e;

    state_e           state_q, state_d;
    logic [WordW-1:0] addr_q, addr_d;  // word address of the current request
    logic [31:0]      wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic             victim_q, victim_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;

    logic [TagW-1:0]            tag_q  [2][NUM_SETS];
    logic [31:0]                data_q [2][NUM_SETS];
    logic [1:0][NUM_SETS-1:0]   valid_q, dirty_q;
    logic [NUM_SETS-1:0]        lru_q;  // way to evict next when both are valid

    logic [31:0]      mem [RAM_WORDS];
    logic             ram_we;
    logic [3:0]       ram_be;
    logic [WordW-1:0] ram_addr;
    logic [31:0]      ram_din, ram_dout_q;

    logic [IdxW-1:0]  idx;
    logic [TagW-1:0]  tag;
    logic             hit0, hit1, hit, hit_way, victim_way;

    // Array write controls, produced by the FSM
    logic             data_we, data_way, fill, mark_dirty, clean_victim, lru_we, lru_val;
    logic [31:0]      data_wval;

    logic             unused_addr_bits;
    assign unused_addr_bits = ^cpu.cpu_addr[1:0];

    assign idx = addr_q[IdxW-1:0];
    assign tag = addr_q[WordW-1:IdxW];

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Invalid way first (way 0 preferred), otherwise the LRU way
    assign victim_way = !valid_q[0][idx] ? 1'b0 :
                        !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ready = ready_q;

    // Backing RAM: only write-backs ever write it; a reset cycle never writes
    assign ram_we   = (state_q == StWriteback) && !rst;
    assign ram_be   = 4'hF;
    assign ram_addr = (state_q == StWriteback) ? {tag_q[victim_q][idx], idx} : addr_q;
    assign ram_din  = data_q[victim_q][idx];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && ram_be[b]) begin
                mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end
        ram_dout_q <= mem[ram_addr];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        victim_d     = victim_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        data_we      = 1'b0;
        data_way     = victim_q;
        data_wval    = wdata_q;
        fill         = 1'b0;
        mark_dirty   = 1'b0;
        clean_victim = 1'b0;
        lru_we       = 1'b0;
        lru_val      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu.cpu_valid) begin
                    addr_d  = cpu.cpu_addr[ADDR_W-1:2];
                    wdata_d = cpu.cpu_wdata;
                    rw_d    = cpu.cpu_rw;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    ready_d = 1'b1;
                    lru_we  = 1'b1;
                    lru_val = ~hit_way;
                    if (rw_q) begin
                        data_we    = 1'b1;
                        data_way   = hit_way;
                        mark_dirty = 1'b1;
                    end else begin
                        rdata_d = data_q[hit_way][idx];
                    end
                    state_d = StIdle;
                end else begin
                    victim_d = victim_way;
                    state_d  = dirty_q[victim_way][idx] ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                clean_victim = 1'b1;
                state_d      = StAllocate;
            end
            StAllocate: begin
                state_d = StRefill;
            end
            StRefill: begin
                // Line fill and the now-hitting access complete on the same edge
                data_we    = 1'b1;
                fill       = 1'b1;
                data_wval  = rw_q ? wdata_q : ram_dout_q;
                mark_dirty = rw_q;
                lru_we     = 1'b1;
                lru_val    = ~victim_q;
                ready_d    = 1'b1;
                if (!rw_q) begin
                    rdata_d = ram_dout_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (data_we && !rst) begin
            data_q[data_way][idx] <= data_wval;
            if (fill) begin
                tag_q[data_way][idx] <= tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            victim_q <= 1'b0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            victim_q <= victim_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            if (fill) begin
                valid_q[data_way][idx] <= 1'b1;
            end
            if (data_we) begin
                dirty_q[data_way][idx] <= mark_dirty;
            end
            if (clean_victim) begin
                dirty_q[victim_q][idx] <= 1'b0;
            end
            if (lru_we) begin
                lru_q[idx] <= lru_val;
            end
        end
    end
endmodule

// File: tb/tb_sa_cache_ram_top.sv
module tb_sa_cache_ram_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sa_cache_ram_top_if #(.ADDR_W(20)) bus ();

    sa_cache_ram_top dut (
        .clk (clk),
        .rst (rst),
        .cpu (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wb_seen = 0;
    int ready_cnt = 0;
    int req_done = 0;

    always @(negedge clk) begin
        if (dut.ram_we) wb_seen++;
        if (bus.cpu_ready) ready_cnt++;
    end

    // Reference model: per set, up to two lines ordered most-recent first
    typedef struct {
        logic [9:0]  tag;
        logic [31:0] data;
        bit          dirty;
    } line_t;

    line_t       lines_m [256][2];
    int          cnt_m [256];
    logic [31:0] mem_m [int];
    logic [31:0] last_rd_m;
    int          wb_m;

    task automatic model_reset();
        for (int s = 0; s < 256; s++) cnt_m[s] = 0;
        last_rd_m = 32'h0;
    endtask

    task automatic model_access(input logic [19:0] a, input logic [31:0] wd, input bit rw,
                                output int lat, output logic [31:0] rd);
        int    s;
        int    word;
        int    hit;
        line_t ln;
        logic [9:0] t;
        s    = int'(a[9:2]);
        t    = a[19:10];
        word = int'(a[19:2]);
        hit  = -1;
        for (int i = 0; i < cnt_m[s]; i++) begin
            if (lines_m[s][i].tag == t) hit = i;
        end
        if (hit >= 0) begin
            lat = 2;
            ln  = lines_m[s][hit];
            if (hit == 1) lines_m[s][1] = lines_m[s][0];
        end else begin
            lat = 4;
            if (cnt_m[s] == 2 && lines_m[s][1].dirty) begin
                mem_m[int'({lines_m[s][1].tag, a[9:2]})] = lines_m[s][1].data;
                wb_m++;
                lat = 5;
            end
            if (cnt_m[s] >= 1) lines_m[s][1] = lines_m[s][0];
            if (cnt_m[s] < 2) cnt_m[s]++;
            ln.tag   = t;
            ln.dirty = 1'b0;
            ln.data  = mem_m.exists(word) ? mem_m[word] : 32'h0;
        end
        if (rw) begin
            ln.data  = wd;
            ln.dirty = 1'b1;
        end else begin
            last_rd_m = ln.data;
        end
        lines_m[s][0] = ln;
        rd = last_rd_m;
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One request; latency counts the accepting edge as 1
    task automatic do_req(input logic [19:0] a, input logic [31:0] wd, input bit rw,
                          input int exp_lat, input logic [31:0] exp_rd, input string nm);
        int lat;
        bit got;
        @(negedge clk);
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_rw    = rw;
        bus.cpu_valid = 1'b1;
        @(posedge clk);
        #1 bus.cpu_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.cpu_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ready within 20 edges, expected ready at edge %0d",
                     nm, exp_lat);
        end else begin
            req_done++;
            check_int({nm, "_latency"}, lat, exp_lat);
            check32({nm, "_rdata"}, bus.cpu_rdata, exp_rd);
            @(posedge clk);
            #1;
            check32({nm, "_ready_pulse"}, {31'h0, bus.cpu_ready}, 32'h0);
        end
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [31:0] wdata;
        bit          rw;
        int          lat;
        logic [31:0] rdata;
        int          wb;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [19:0] a;
        logic [31:0] wd;
        bit          rw;
        int          s;
        int          t;

        vecs[0]  = '{20'h00000, 32'h00000000, 1'b1, 4, 32'h00000000, 0};
        vecs[1]  = '{20'h00004, 32'h00000004, 1'b1, 4, 32'h00000000, 0};
        vecs[2]  = '{20'h00008, 32'h00000008, 1'b1, 4, 32'h00000000, 0};
        vecs[3]  = '{20'h0000C, 32'h0000000C, 1'b1, 4, 32'h00000000, 0};
        vecs[4]  = '{20'h00000, 32'h0,        1'b0, 2, 32'h00000000, 0};
        vecs[5]  = '{20'h00004, 32'h0,        1'b0, 2, 32'h00000004, 0};
        vecs[6]  = '{20'h00008, 32'h0,        1'b0, 2, 32'h00000008, 0};
        vecs[7]  = '{20'h0000C, 32'h0,        1'b0, 2, 32'h0000000C, 0};
        vecs[8]  = '{20'h8000C, 32'h0008000C, 1'b1, 4, 32'h0000000C, 0};
        vecs[9]  = '{20'hC000C, 32'h000C000C, 1'b1, 5, 32'h0000000C, 1};
        vecs[10] = '{20'h0000C, 32'h0,        1'b0, 5, 32'h0000000C, 2};
        vecs[11] = '{20'h40010, 32'h0,        1'b0, 4, 32'h00000000, 2};

        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_rw    = 1'b0;
        bus.cpu_valid = 1'b0;
        wb_m = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check32("reset_ready", {31'h0, bus.cpu_ready}, 32'h0);
        check32("reset_rdata", bus.cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model_access(vecs[i].addr, vecs[i].wdata, vecs[i].rw, lat, rd);
            do_req(vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].lat, vecs[i].rdata,
                   $sformatf("vec%0d", i));
            check_int($sformatf("vec%0d_writebacks", i), wb_seen, vecs[i].wb);
        end
        check32("ram_word_0000C", dut.mem[18'h00003], 32'h0000000C);
        check32("ram_word_8000C", dut.mem[18'h20003], 32'h0008000C);

        // Clean miss of 0x00400 (set 0, way 1 free), reset lands on the REFILL edge
        @(negedge clk);
        bus.cpu_addr  = 20'h00400;
        bus.cpu_rw    = 1'b0;
        bus.cpu_valid = 1'b1;
        @(posedge clk);
        #1 bus.cpu_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_refill_ready", {31'h0, bus.cpu_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check32("rst_refill_no_ready", {31'h0, bus.cpu_ready}, 32'h0);
        end
        model_reset();
        model_access(20'h0000C, 32'h0, 1'b0, lat, rd);
        do_req(20'h0000C, 32'h0, 1'b0, 4, 32'h0000000C, "post_rst_0000C");
        model_access(20'h00000, 32'h0, 1'b0, lat, rd);
        do_req(20'h00000, 32'h0, 1'b0, 4, 32'h00000000, "post_rst_00000");

        // Random traffic over 4 sets x 4 tags to force conflicts and evictions
        for (int n = 0; n < 300; n++) begin
            s  = $urandom_range(0, 3);
            t  = $urandom_range(0, 3);
            a  = {t[9:0], s[7:0], 2'b00};
            rw = 1'($urandom_range(0, 1));
            wd = $urandom;
            model_access(a, wd, rw, lat, rd);
            do_req(a, wd, rw, lat, rd, $sformatf("rand%0d_%s_%05h", n, rw ? "wr" : "rd", a));
        end

        check_int("total_writebacks", wb_seen, wb_m);
        check_int("total_ready_pulses", ready_cnt, req_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
